// File: rtl/cache_pkg.sv
// Shared definitions for the CPU cache sequencer: address width, clear-sweep
// end address and the sequencer state encoding.
package cache_pkg;

  localparam int unsigned     CA_W     = 11;
  localparam logic [CA_W-1:0] CLR_LAST = 11'd2047;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEMRD,
    FILL,
    MEMWR,
    WCACHE,
    CLEAR
  } state_t;

endpackage

// File: rtl/cache_clr_cnt.sv
// Clear-sweep address counter: counts 0..CLR_LAST while start is held and
// flags the final address so the sequencer can leave CLEAR.
module cache_clr_cnt
  import cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [CA_W-1:0] ca,
  output logic            last
);

  logic [CA_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign ca   = r_cnt;
  assign last = start && (r_cnt == CLR_LAST);

endmodule

// File: rtl/cpu_mmu_cache_seq.sv
// CPU cache access sequencer: lookup, read fill, write-through and full clear.
// Optional hit/miss statistics outputs are enabled with `define CACHE_STATS_EN.
module cpu_mmu_cache_seq
  import cache_pkg::*;
(
  input  logic            sysclk,
  input  logic            sys_rst_n,
  input  logic            cpu_req,
  input  logic            cpu_wr,
  input  logic [CA_W-1:0] cpu_idx,
  input  logic            hit,
  input  logic            wcinh_n,
  input  logic            mem_ack,
  input  logic            clr_req,
  output logic [CA_W-1:0] ca,
  output logic            ecd_n,
  output logic            wca_n,
  output logic            inval,
  output logic            mem_req,
  output logic            cpu_rdy,
  output logic            busy,
  output logic            clr_done
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]     hit_cnt,
  output logic [15:0]     miss_cnt
`endif
);

  state_t          r_state;
  state_t          w_next;
  logic [CA_W-1:0] r_ca;
  logic            r_wr;
  logic            r_hit;
  logic            r_pend;
  logic            r_cpu_rdy;
  logic            r_clr_done;
  logic            w_rdy_set;
  logic            w_clr_run;
  logic            w_clr_last;
  logic [CA_W-1:0] w_clr_ca;

  assign w_clr_run = (r_state == CLEAR);

  cache_clr_cnt u_clr_cnt (
    .clk   (sysclk),
    .rst_n (sys_rst_n),
    .start (w_clr_run),
    .ca    (w_clr_ca),
    .last  (w_clr_last)
  );

  // cpu_rdy is registered, so the CPU still holds cpu_req during the idle
  // cycle that shows cpu_rdy; that cycle must not start a new lookup.
  always_comb begin
    w_next    = r_state;
    w_rdy_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend || clr_req) begin
          w_next = CLEAR;
        end else if (cpu_req && !r_cpu_rdy) begin
          w_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (r_wr) begin
          w_next = MEMWR;
        end else if (hit) begin
          w_next    = IDLE;
          w_rdy_set = 1'b1;
        end else begin
          w_next = MEMRD;
        end
      end
      MEMRD: begin
        if (mem_ack) begin
          w_next    = FILL;
          w_rdy_set = 1'b1;
        end
      end
      FILL: w_next = IDLE;
      MEMWR: begin
        if (mem_ack) begin
          w_rdy_set = 1'b1;
          w_next    = (r_hit && wcinh_n) ? WCACHE : IDLE;
        end
      end
      WCACHE: w_next = IDLE;
      CLEAR: begin
        if (w_clr_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_ca       <= '0;
      r_wr       <= 1'b0;
      r_hit      <= 1'b0;
      r_pend     <= 1'b0;
      r_cpu_rdy  <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cpu_rdy  <= w_rdy_set;
      r_clr_done <= w_clr_last;
      if (r_state == IDLE && w_next == LOOKUP) begin
        r_ca <= cpu_idx;
        r_wr <= cpu_wr;
      end else if (r_state == CLEAR) begin
        r_ca <= '0;
      end
      if (r_state == LOOKUP) begin
        r_hit <= hit;
      end
      if (r_state == IDLE && w_next == CLEAR) begin
        r_pend <= 1'b0;
      end else if (clr_req && r_state != IDLE) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign ca       = w_clr_run ? w_clr_ca : r_ca;
  assign ecd_n    = !(r_state == LOOKUP || r_state == FILL ||
                      r_state == WCACHE || r_state == CLEAR);
  assign wca_n    = !((r_state == FILL && wcinh_n) || r_state == WCACHE ||
                      r_state == CLEAR);
  assign inval    = w_clr_run;
  assign mem_req  = (r_state == MEMRD) || (r_state == MEMWR);
  assign busy     = (r_state != IDLE);
  assign cpu_rdy  = r_cpu_rdy;
  assign clr_done = r_clr_done;

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  // Counters zero together with the clr_done pulse of a completed sweep.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_clr_last) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == LOOKUP && !r_wr) begin
      if (hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 16'd1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/cpu_mmu_cache_seq.md
CPU_MMU_CACHE_SEQ -- requirements
Module: cpu_mmu_cache_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, using the codebase's port names sysclk and sys_rst_n.
REQ-002 Port sysclk SHALL be input, 1 bit: the FPGA system clock; all state changes on its rising edge.
REQ-003 Port sys_rst_n SHALL be input, 1 bit: asynchronous active-low reset.
REQ-004 Port cpu_req SHALL be input, 1 bit: CPU cycle request, held until cpu_rdy.
REQ-005 Port cpu_wr SHALL be input, 1 bit: 1 = write cycle, 0 = read; valid with cpu_req.
REQ-006 Port cpu_idx SHALL be input, 11 bits: cache index (CA 10:0), valid with cpu_req.
REQ-007 Port hit SHALL be input, 1 bit: tag-match result from the cache datapath, valid the cycle after ca/ecd_n are driven.
REQ-008 Port wcinh_n SHALL be input, 1 bit: 0 inhibits all cache writes except clear.
REQ-009 Port mem_ack SHALL be input, 1 bit: one-cycle memory completion pulse.
REQ-010 Port clr_req SHALL be input, 1 bit: one-cycle cache-clear request pulse.
REQ-011 Outputs SHALL be: ca (11 bits, cache address); ecd_n (1 bit, cache chip enable); wca_n (1 bit, cache write strobe); inval (1 bit, forces invalid/used-bit-clear data); mem_req (1 bit); cpu_rdy (1 bit, one-cycle pulse); busy (1 bit); clr_done (1 bit, one-cycle pulse).

Function
REQ-012 States SHALL be IDLE, LOOKUP, MEMRD, FILL, MEMWR, WCACHE, CLEAR.
REQ-013 IDLE: clear pending -> CLEAR (priority over cpu_req); else cpu_req -> LOOKUP with ca <= cpu_idx, ecd_n <= 0.
REQ-014 LOOKUP (1 cycle): hit sampled; read hit -> IDLE with cpu_rdy pulse (cpu_rdy 2 cycles after cpu_req first sampled); read miss -> MEMRD; write -> MEMWR.
REQ-015 MEMRD: mem_req = 1 until mem_ack; on mem_ack -> FILL.
REQ-016 FILL (1 cycle): wca_n = 0 only if wcinh_n = 1; cpu_rdy pulses; next IDLE.
REQ-017 MEMWR: mem_req = 1 until mem_ack; then WCACHE if latched hit and wcinh_n = 1, else IDLE with cpu_rdy pulse.
REQ-018 WCACHE (1 cycle): wca_n = 0, cpu_rdy pulses; next IDLE.
REQ-019 CLEAR: ca starts at 0 and increments each cycle with wca_n = 0, inval = 1, ecd_n = 0; after 2047 ca wraps to 0, clr_done pulses, next IDLE; 2048 cycles total.
REQ-020 clr_req arriving in any state other than IDLE SHALL set a one-bit pending flag; multiple requests collapse into one; the flag clears on entry to CLEAR.
REQ-021 clr_req arriving during CLEAR SHALL restart nothing; it is recorded as pending and yields one more sweep.
REQ-022 busy SHALL be 1 in every state except IDLE; cpu_req is ignored while busy except as held request.
REQ-023 mem_ack outside MEMRD/MEMWR SHALL be ignored.
REQ-024 wca_n SHALL be 0 for exactly one cycle per write, never in IDLE or LOOKUP.

Reset
REQ-025 sys_rst_n = 0 SHALL immediately force IDLE, ca = 0, ecd_n = 1, wca_n = 1, inval = 0, mem_req = 0, cpu_rdy = 0, busy = 0, clr_done = 0, pending = 0, also mid-sweep or mid-memory cycle.

Configuration
REQ-026 With CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt and miss_cnt (16 bits, saturating at 0xFFFF, counted per LOOKUP on reads only, reset to 0, cleared by clr_done); without it, these outputs and counters SHALL not exist.

Structure
REQ-027 Shared package cache_pkg SHALL hold the state enum, CA_W = 11, and CLR_LAST = 2047.
REQ-028 The clear sweep counter SHALL be a sub-module cache_clr_cnt (start, ca, last).

Verification
REQ-029 Read hit: cpu_req, cpu_idx = 0x123, hit = 1 -> ca = 0x123, cpu_rdy 2 cycles later, mem_req never 1.
REQ-030 Read miss: hit = 0, mem_ack 5 cycles later -> mem_req high 5 cycles, wca_n low 1 cycle in FILL, cpu_rdy same cycle.
REQ-031 Write hit with wcinh_n = 0 -> mem_req until mem_ack, no wca_n low, cpu_rdy pulse.
REQ-032 clr_req during MEMRD -> read completes, then 2048 wca_n pulses with ca 0..2047, clr_done once, ca = 0 after.
REQ-033 Reset asserted at sweep address 0x400 -> all outputs at reset values asynchronously; no clr_done.
REQ-034 CACHE_STATS_EN: 3 read hits, 1 miss -> hit_cnt = 3, miss_cnt = 1; then clear -> both 0.
